// File: rtl/riscv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_enc_pkg
//  Description : Shared constants and types for the RV64I immediate encoder:
//                major opcodes, request kind enumeration, canonical NOP,
//                encoder FSM state type and instruction-field packing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_enc_pkg;

  // Major opcodes used by the encoder
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  // ADDI x0,x0,0 -- also the payload of every error beat
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Request kinds; encodings 9..15 are illegal
  typedef enum logic [3:0] {
    KIND_ITY    = 4'd0,
    KIND_LOAD   = 4'd1,
    KIND_STORE  = 4'd2,
    KIND_BRANCH = 4'd3,
    KIND_JALR   = 4'd4,
    KIND_JAL    = 4'd5,
    KIND_AUIPC  = 4'd6,
    KIND_LUI    = 4'd7,
    KIND_LI     = 4'd8
  } kind_e;

  // Encoder output FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2
  } state_e;

  // I-format packing: imm[11:0] | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_i(input logic [11:0] imm,
                                        input logic [4:0]  rs1,
                                        input logic [2:0]  funct3,
                                        input logic [4:0]  rd,
                                        input logic [6:0]  opcode);
    return {imm, rs1, funct3, rd, opcode};
  endfunction

  // U-format packing: imm[31:12] | rd | opcode
  function automatic logic [31:0] enc_u(input logic [19:0] imm_hi,
                                        input logic [4:0]  rd,
                                        input logic [6:0]  opcode);
    return {imm_hi, rd, opcode};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_range_chk.sv
`default_nettype none
// ============================================================================
//  Module      : imm_range_chk
//  Description : Combinational immediate range checker. Decides whether the
//                immediate of a request is encodable for its kind.
//                Optional feature macro: IMMENC_LI_EN (adds LI checks and the
//                li_short output).
//  Ports       : kind      - request kind (4 bits, 9..15 illegal)
//                imm       - two's-complement immediate, DATA_LEN bits
//                in_range  - 1 when the kind is legal and imm is encodable
//                li_short  - (IMMENC_LI_EN only) LI fits a single ADDI
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_range_chk
  import riscv_enc_pkg::*;
#(
  parameter int DATA_LEN = 64
) (
  input  logic [3:0]          kind,
  input  logic [DATA_LEN-1:0] imm,
  output logic                in_range
`ifdef IMMENC_LI_EN
  ,
  output logic                li_short
`endif
);

  // "All bits from n upward equal" == value is representable as an
  // (n+1)-bit signed number.
  logic sx11;
  logic sx12;
  logic sx20;
  logic sx31;

  assign sx11 = (&imm[DATA_LEN-1:11]) | ~(|imm[DATA_LEN-1:11]);
  assign sx12 = (&imm[DATA_LEN-1:12]) | ~(|imm[DATA_LEN-1:12]);
  assign sx20 = (&imm[DATA_LEN-1:20]) | ~(|imm[DATA_LEN-1:20]);
  assign sx31 = (&imm[DATA_LEN-1:31]) | ~(|imm[DATA_LEN-1:31]);

`ifdef IMMENC_LI_EN
  // Positive values from 0x7FFFF800 up would need hi = 0x80000, which LUI
  // sign-extends to a negative number on RV64.
  logic li_top;
  assign li_top   = ~imm[31] & (&imm[30:11]);
  assign li_short = sx11;
`endif

  always_comb begin
    in_range = 1'b0;
    case (kind_e'(kind))
      KIND_ITY,
      KIND_LOAD,
      KIND_JALR,
      KIND_STORE:  in_range = sx11;
      KIND_BRANCH: in_range = sx12 & ~imm[0];
      KIND_JAL:    in_range = sx20 & ~imm[0];
      KIND_AUIPC,
      KIND_LUI:    in_range = sx31 & ~(|imm[11:0]);
`ifdef IMMENC_LI_EN
      KIND_LI:     in_range = sx31 & ~li_top;
`endif
      default:     in_range = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Encodes an RV64I instruction request (kind, registers,
//                funct3, immediate) into one or two 32-bit instruction beats
//                on a valid/ready output stream. Unencodable immediates and
//                illegal kinds yield a single NOP beat flagged with err_o.
//                Optional feature macro: IMMENC_LI_EN enables the LI pseudo
//                instruction (ADDI, or LUI followed by an optional ADDI).
//  Ports       : clk, rst_n                 - clock / async active-low reset
//                req_valid_i, req_ready_o   - request handshake
//                req_kind_i, req_rd_i, req_rs1_i, req_rs2_i, req_funct3_i,
//                req_imm_i                  - request fields
//                inst_valid_o, inst_ready_i - instruction beat handshake
//                inst_o, inst_last_o, err_o - beat payload
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
  import riscv_enc_pkg::*;
#(
  parameter int DATA_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [3:0]          req_kind_i,
  input  logic [4:0]          req_rd_i,
  input  logic [4:0]          req_rs1_i,
  input  logic [4:0]          req_rs2_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [DATA_LEN-1:0] req_imm_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [31:0]         inst_o,
  output logic                inst_last_o,
  output logic                err_o
);

  state_e      state;
  state_e      state_nxt;
  logic        accept;
  logic        in_range;

  logic [31:0] word1_c;
  logic        last1_c;
  logic        err1_c;

  logic [31:0] inst_q;
  logic        last_q;
  logic        err_q;

`ifdef IMMENC_LI_EN
  logic        li_short;
  logic [19:0] li_hi;
  logic [31:0] word2_c;
  logic [31:0] word2_q;
`endif

  imm_range_chk #(
    .DATA_LEN (DATA_LEN)
  ) u_range_chk (
    .kind     (req_kind_i),
    .imm      (req_imm_i),
    .in_range (in_range)
`ifdef IMMENC_LI_EN
    ,
    .li_short (li_short)
`endif
  );

  // Requests are only taken in IDLE; the reset gate keeps ready low while
  // rst_n is asserted even though the state register already reads IDLE.
  assign accept       = (state == ST_IDLE) & req_valid_i;
  assign req_ready_o  = rst_n & (state == ST_IDLE);
  assign inst_valid_o = (state != ST_IDLE);
  assign inst_o       = inst_q;
  assign inst_last_o  = last_q;
  assign err_o        = err_q;

  // --------------------------------------------------------------------------
  // Encoding of the raw request. Both beats are computed at acceptance, so
  // later changes of the request inputs cannot disturb an ongoing request.
  // --------------------------------------------------------------------------
  always_comb begin
    word1_c = INST_NOP;
    last1_c = 1'b1;
    err1_c  = 1'b0;
`ifdef IMMENC_LI_EN
    word2_c = '0;
    // hi = (imm + 0x800) >> 12, truncated to the 20-bit LUI field; the low
    // 12 bits of imm are then exactly the sign-extended ADDI immediate.
    li_hi   = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
`endif
    case (kind_e'(req_kind_i))
      KIND_ITY:    word1_c = enc_i(req_imm_i[11:0], req_rs1_i, req_funct3_i,
                                   req_rd_i, OPC_OP_IMM);
      KIND_LOAD:   word1_c = enc_i(req_imm_i[11:0], req_rs1_i, req_funct3_i,
                                   req_rd_i, OPC_LOAD);
      KIND_JALR:   word1_c = enc_i(req_imm_i[11:0], req_rs1_i, req_funct3_i,
                                   req_rd_i, OPC_JALR);
      KIND_STORE:  word1_c = {req_imm_i[11:5], req_rs2_i, req_rs1_i,
                              req_funct3_i, req_imm_i[4:0], OPC_STORE};
      KIND_BRANCH: word1_c = {req_imm_i[12], req_imm_i[10:5], req_rs2_i,
                              req_rs1_i, req_funct3_i, req_imm_i[4:1],
                              req_imm_i[11], OPC_BRANCH};
      KIND_JAL:    word1_c = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                              req_imm_i[19:12], req_rd_i, OPC_JAL};
      KIND_AUIPC:  word1_c = enc_u(req_imm_i[31:12], req_rd_i, OPC_AUIPC);
      KIND_LUI:    word1_c = enc_u(req_imm_i[31:12], req_rd_i, OPC_LUI);
`ifdef IMMENC_LI_EN
      KIND_LI: begin
        if (li_short) begin
          word1_c = enc_i(req_imm_i[11:0], 5'd0, 3'd0, req_rd_i, OPC_OP_IMM);
        end else begin
          word1_c = enc_u(li_hi, req_rd_i, OPC_LUI);
          // A zero low part needs no trailing ADDI
          if (req_imm_i[11:0] != 12'd0) begin
            last1_c = 1'b0;
            word2_c = enc_i(req_imm_i[11:0], req_rd_i, 3'd0, req_rd_i,
                            OPC_OP_IMM);
          end
        end
      end
`endif
      default: word1_c = INST_NOP;
    endcase

    // Illegal kind or unencodable immediate: single error beat
    if (!in_range) begin
      word1_c = INST_NOP;
      last1_c = 1'b1;
      err1_c  = 1'b1;
`ifdef IMMENC_LI_EN
      word2_c = '0;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) state_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        if (inst_ready_i) begin
`ifdef IMMENC_LI_EN
          state_nxt = last_q ? ST_IDLE : ST_BEAT2;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_BEAT2: begin
        if (inst_ready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / beat registers. Payload only changes on acceptance or on the
  // BEAT1 -> BEAT2 handshake, so it is stable while a beat is stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMMENC_LI_EN
      word2_q <= '0;
`endif
    end else begin
      if (accept) begin
        inst_q  <= word1_c;
        last_q  <= last1_c;
        err_q   <= err1_c;
`ifdef IMMENC_LI_EN
        word2_q <= word2_c;
`endif
      end
`ifdef IMMENC_LI_EN
      else if ((state == ST_BEAT1) && inst_ready_i && !last_q) begin
        inst_q <= word2_q;
        last_q <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Self-checking bench for imm_encoder: directed vector table,
//                stall and mid-request reset sequences, then randomized
//                requests against a behavioural reference model.
//                Honours IMMENC_LI_EN for the expected LI behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

  localparam int     DATA_LEN = 64;
  localparam longint P2_31    = 64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  kind = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [63:0] imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        inst_last;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_encoder #(.DATA_LEN(DATA_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_kind_i   (kind),
    .req_rd_i     (rd),
    .req_rs1_i    (rs1),
    .req_rs2_i    (rs2),
    .req_funct3_i (f3),
    .req_imm_i    (imm),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_o       (inst),
    .inst_last_o  (inst_last),
    .err_o        (err)
  );

  typedef struct {
    logic [3:0]  k;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [2:0]  fn;
    longint      v;
    int          nb;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input longint v, input longint lo, input longint hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Reference model: number of beats, words and error flag from the ISA rules
  function automatic void model(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] fn, input longint v,
                                output int nb, output logic [31:0] w0, output logic [31:0] w1,
                                output logic e);
    logic [63:0] u;
    logic [63:0] hv;
    logic [63:0] lv;
    longint      hi;
    longint      lo;
    bit          ok;
    u  = v;
    nb = 1;
    w0 = 32'h13;
    w1 = 32'h0;
    e  = 1'b0;
    ok = 1'b0;
    case (k)
      4'd0, 4'd1, 4'd4: begin
        ok = in_rng(v, -2048, 2047);
        w0 = {u[11:0], s1, fn, d, (k == 4'd0) ? 7'h13 : ((k == 4'd1) ? 7'h03 : 7'h67)};
      end
      4'd2: begin
        ok = in_rng(v, -2048, 2047);
        w0 = {u[11:5], s2, s1, fn, u[4:0], 7'h23};
      end
      4'd3: begin
        ok = in_rng(v, -4096, 4095) && (v % 2 == 0);
        w0 = {u[12], u[10:5], s2, s1, fn, u[4:1], u[11], 7'h63};
      end
      4'd5: begin
        ok = in_rng(v, -1048576, 1048575) && (v % 2 == 0);
        w0 = {u[20], u[10:1], u[11], u[19:12], d, 7'h6f};
      end
      4'd6, 4'd7: begin
        ok = in_rng(v, -P2_31, P2_31 - 1) && (v % 4096 == 0);
        w0 = {u[31:12], d, (k == 4'd6) ? 7'h17 : 7'h37};
      end
`ifdef IMMENC_LI_EN
      4'd8: begin
        ok = in_rng(v, -P2_31, 64'sh7FFFF7FF);
        if (in_rng(v, -2048, 2047)) begin
          w0 = {u[11:0], 5'd0, 3'd0, d, 7'h13};
        end else begin
          hi = (v + 2048) >>> 12;
          lo = v - (hi <<< 12);
          hv = hi;
          lv = lo;
          w0 = {hv[19:0], d, 7'h37};
          if (lo != 0) begin
            nb = 2;
            w1 = {lv[11:0], d, 3'd0, d, 7'h13};
          end
        end
      end
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      nb = 1;
      w0 = 32'h13;
      w1 = 32'h0;
      e  = 1'b1;
    end
  endfunction

  function automatic vec_t mk(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] fn, input longint v,
                              input int nb, input logic [31:0] w0, input logic [31:0] w1,
                              input logic e);
    vec_t r;
    r.k = k; r.d = d; r.s1 = s1; r.s2 = s2; r.fn = fn; r.v = v;
    r.nb = nb; r.w0 = w0; r.w1 = w1; r.e = e;
    return r;
  endfunction

  function automatic vec_t mk_err(input logic [3:0] k, input logic [4:0] d, input longint v);
    return mk(k, d, 5'd0, 5'd0, 3'd0, v, 1, 32'h13, 32'h0, 1'b1);
  endfunction

  // Called at #1 after a rising edge. stall1 >= 0: beat 1 held off for
  // stall1 cycles, all later beats accepted at once; stall1 < 0: random ready.
  task automatic run_req(input string tag, input vec_t v, input int stall1);
    int beat;
    int cyc;
    int held;
    kind = v.k; rd = v.d; rs1 = v.s1; rs2 = v.s2; f3 = v.fn; imm = v.v;
    req_valid = 1'b1;
    check({tag, " req_ready idle"}, req_ready, 1'b1);
    check({tag, " valid before accept"}, inst_valid, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // scramble the request inputs; the encoder must have captured them
    kind = 4'($urandom()); rd = 5'($urandom()); rs1 = 5'($urandom());
    rs2 = 5'($urandom()); f3 = 3'($urandom()); imm = {$urandom(), $urandom()};
    beat = 0;
    cyc  = 0;
    held = 0;
    while (beat < v.nb) begin
      check({tag, " inst_valid"}, inst_valid, 1'b1);
      check({tag, " req_ready busy"}, req_ready, 1'b0);
      check({tag, " inst"}, inst, (beat == 0) ? v.w0 : v.w1);
      check({tag, " last"}, inst_last, (beat == v.nb - 1) ? 1'b1 : 1'b0);
      check({tag, " err"}, err, v.e);
      if (stall1 >= 0) begin
        inst_ready = !((beat == 0) && (held < stall1));
        if (!inst_ready) held++;
      end else begin
        inst_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      if (inst_ready) beat++;
      cyc++;
      if (cyc > 60) begin
        check({tag, " beat timeout"}, 1'b1, 1'b0);
        break;
      end
    end
    inst_ready = 1'b0;
    check({tag, " valid after last"}, inst_valid, 1'b0);
    check({tag, " ready after last"}, req_ready, 1'b1);
  endtask

  vec_t   tbl[14];
  vec_t   rv;
  longint bnd[16];

  initial begin
    // ---------------------------------------------------------------- reset
    repeat (2) @(posedge clk);
    #1;
    check("reset inst_valid", inst_valid, 1'b0);
    check("reset inst", inst, 32'h0);
    check("reset last", inst_last, 1'b0);
    check("reset err", err, 1'b0);
    check("reset req_ready", req_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ----------------------------------------------------------- vector table
    tbl[0]  = mk(4'd0, 5'd5, 5'd6, 5'd0, 3'd0, -1, 1, 32'hFFF30293, 32'h0, 1'b0);
    tbl[1]  = mk_err(4'd3, 5'd0, 64'sh1000);
    tbl[2]  = mk_err(4'd3, 5'd0, 3);
    tbl[3]  = mk_err(4'd8, 5'd0, 64'sh7FFFF800);
    tbl[4]  = mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 64'sh800, 1, 32'h001000EF, 32'h0, 1'b0);
    tbl[5]  = mk(4'd2, 5'd0, 5'd2, 5'd3, 3'd3, -8, 1, 32'hFE313C23, 32'h0, 1'b0);
    tbl[6]  = mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 64'sh12345000, 1, 32'h123450B7, 32'h0, 1'b0);
    tbl[7]  = mk_err(4'd9, 5'd0, 0);
    tbl[8]  = mk(4'd3, 5'd0, 5'd1, 5'd2, 3'd1, -4096, 1, 32'h80209063, 32'h0, 1'b0);
    tbl[9]  = mk_err(4'd0, 5'd1, 2048);
    tbl[10] = mk(4'd0, 5'd1, 5'd0, 5'd0, 3'd0, -2048, 1, 32'h80000093, 32'h0, 1'b0);
`ifdef IMMENC_LI_EN
    tbl[11] = mk(4'd8, 5'd10, 5'd0, 5'd0, 3'd0, 64'sh12345FFF, 2, 32'h12346537, 32'hFFF50513, 1'b0);
    tbl[12] = mk(4'd8, 5'd10, 5'd0, 5'd0, 3'd0, 64'sh800, 2, 32'h00001537, 32'h80050513, 1'b0);
    tbl[13] = mk(4'd8, 5'd3, 5'd0, 5'd0, 3'd0, 64'sh1000, 1, 32'h000011B7, 32'h0, 1'b0);
`else
    tbl[11] = mk_err(4'd8, 5'd10, 64'sh12345FFF);
    tbl[12] = mk_err(4'd8, 5'd10, 64'sh800);
    tbl[13] = mk_err(4'd8, 5'd3, 64'sh1000);
`endif
    for (int i = 0; i < 14; i++) begin
      run_req($sformatf("vec%0d", i), tbl[i], -1);
    end

    // -------------------------------------------- stalled first LI beat
    run_req("stall", tbl[11], 3);

    // --------------------------------------- reset between the LI beats
    kind = 4'd8; rd = 5'd10; rs1 = 5'd0; rs2 = 5'd0; f3 = 3'd0; imm = 64'h12345FFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst beat1 valid", inst_valid, 1'b1);
    inst_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async valid", inst_valid, 1'b0);
    check("rst async inst", inst, 32'h0);
    check("rst async last", inst_last, 1'b0);
    check("rst async err", err, 1'b0);
    check("rst async ready", req_ready, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst no stale beat", inst_valid, 1'b0);
    end
    inst_ready = 1'b0;
    check("rst ready after", req_ready, 1'b1);

    // ---------------------------------------------------------- random
    bnd = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 1048574, 1048576,
            -1048576, 64'sh7FFFF7FF, 64'sh7FFFF800, -P2_31, -P2_31 - 1, 0, 64'sh7FFFF000};
    for (int n = 0; n < 200; n++) begin
      rv.k  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      rv.d  = 5'($urandom());
      rv.s1 = 5'($urandom());
      rv.s2 = 5'($urandom());
      rv.fn = 3'($urandom());
      case ($urandom_range(0, 5))
        0: rv.v = longint'($urandom_range(0, 8191)) - 4096;
        1: rv.v = {$urandom(), $urandom()};
        2: rv.v = longint'($signed($urandom()));
        3: rv.v = longint'($signed($urandom())) & ~64'shFFF;
        4: rv.v = bnd[$urandom_range(0, 15)];
        default: rv.v = (longint'($urandom_range(0, 4194303)) - 2097152) & ~64'sh1;
      endcase
      model(rv.k, rv.d, rv.s1, rv.s2, rv.fn, rv.v, rv.nb, rv.w0, rv.w1, rv.e);
      run_req($sformatf("rnd%0d k%0d", n, rv.k), rv, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter DATA_LEN, default 64: width of the immediate operand.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  encode request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-006 SHALL have port req_kind_i  input  4  kind: 0 ITY, 1 LOAD, 2 STORE, 3 BRANCH, 4 JALR, 5 JAL, 6 AUIPC, 7 LUI, 8 LI; 9-15 illegal.
REQ-007 SHALL have ports req_rd_i, req_rs1_i, req_rs2_i  input  5 each  register fields.
REQ-008 SHALL have port req_funct3_i  input  3  funct3 field.
REQ-009 SHALL have port req_imm_i  input  DATA_LEN  two's-complement byte immediate.
REQ-010 SHALL have port inst_valid_o  output  1  instruction beat valid.
REQ-011 SHALL have port inst_ready_i  input  1  downstream accepts beat.
REQ-012 SHALL have port inst_o  output  32  encoded instruction word.
REQ-013 SHALL have port inst_last_o  output  1  final beat of the request.
REQ-014 SHALL have port err_o  output  1  beat is an error response.

Function
REQ-015 SHALL encode standard RV64I formats: I (ITY/LOAD/JALR), S, B, J, U; opcodes 0x13, 0x03, 0x23, 0x63, 0x67, 0x6f, 0x17, 0x37.
REQ-016 SHALL use range checks: I/S: imm[DATA_LEN-1:11] all equal; B: 13-bit signed, imm[0]=0; J: 21-bit signed, imm[0]=0; U: imm[11:0]=0, imm[DATA_LEN-1:31] all equal.
REQ-017 SHALL emit LI as a single ADDI rd,x0,imm when imm fits 12-bit signed; otherwise as LUI rd,hi then ADDI rd,rd,lo with hi=(imm+0x800)>>12 and lo=imm-(hi<<12); the ADDI SHALL be omitted when lo=0.
REQ-018 SHALL flag LI with imm outside [-2^31, 0x7FFFF7FF] as out of range.
REQ-019 SHALL answer an out-of-range immediate or an illegal kind with exactly one beat: inst_o=0x00000013, err_o=1, inst_last_o=1.
REQ-020 SHALL implement FSM IDLE -> BEAT1 on acceptance; BEAT1 -> BEAT2 on handshake when a second beat exists, else -> IDLE; BEAT2 -> IDLE on handshake.
REQ-021 SHALL drive req_ready_o=1 only in IDLE, with no same-cycle accept on the final handshake.
REQ-022 SHALL register outputs: inst_valid_o rises exactly one cycle after acceptance.
REQ-023 SHALL hold inst_o, inst_last_o and err_o stable while inst_valid_o=1 and inst_ready_i=0.
REQ-024 SHALL capture all request fields at acceptance and ignore request inputs thereafter until IDLE.
REQ-025 SHALL produce zero on rs fields unused by the format; rs2 SHALL be taken only for S and B.

Reset
REQ-026 SHALL, on rst_n low, immediately force state IDLE, inst_valid_o=0, inst_o=0, inst_last_o=0, err_o=0, and req_ready_o=0 while rst_n is low.
REQ-027 SHALL discard a pending second LI beat on reset mid-request; no beat appears after release until a new request is accepted.

Configuration
REQ-028 SHALL, with IMMENC_LI_EN defined, support kind 8 (LI) including BEAT2.
REQ-029 SHALL, without IMMENC_LI_EN, treat kind 8 as illegal (REQ-019 error beat) and never enter BEAT2.

Structure
REQ-030 SHALL take opcode constants, the kind enumeration, the NOP constant and the FSM state type from shared package riscv_enc_pkg.
REQ-031 SHALL place all range checks in one combinational sub-module, imm_range_chk.

Verification
REQ-032 SHALL be verified with: ITY rd=5 rs1=6 f3=0 imm=-1 -> one beat 0xFFF30293, last=1, err=0.
REQ-033 SHALL be verified with: BRANCH imm=0x1000, and separately imm=3 -> each one beat 0x00000013, err=1.
REQ-034 SHALL be verified with: LI rd=10 imm=0x12345FFF -> 0x12346537 (last=0), then 0xFFF50513 (last=1); LI imm=0x800 -> 0x00001537, 0x80050513.
REQ-035 SHALL be verified with: LI imm=0x7FFFF800 -> error beat; JAL rd=1 imm=0x800 -> 0x001000EF.
REQ-036 SHALL be verified with: inst_ready_i low 3 cycles on LI beat 1 -> word held stable, req_ready_o=0 until beat 2 handshake.
REQ-037 SHALL be verified with: rst_n pulsed low between LI beats -> outputs 0 immediately, no second beat ever appears.
